// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI request bridge: frame layout, widths,
// response-FSM states and the frame packing helper.
package spi_bridge_pkg;

  localparam int FRAME_W        = 41;
  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 32;
  localparam int FRAME_WR_BIT   = 40;
  localparam int FRAME_ADDR_MSB = 39;
  localparam int FRAME_ADDR_LSB = 32;
  localparam int FRAME_DATA_MSB = 31;
  localparam int FRAME_DATA_LSB = 0;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_WAIT    = 2'd1,
    R_DELIVER = 2'd2
  } rsp_state_e;

  // Reads carry no payload, so their data field is forced to zero.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic              wr,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] wdata);
    logic [FRAME_W-1:0] f;
    f                                 = '0;
    f[FRAME_WR_BIT]                   = wr;
    f[FRAME_ADDR_MSB:FRAME_ADDR_LSB]  = addr;
    f[FRAME_DATA_MSB:FRAME_DATA_LSB]  = wr ? wdata : 32'd0;
    return f;
  endfunction

endpackage

// File: rtl/spi_tag_fifo.sv
// Small FIFO holding the requester index of every outstanding read, in
// issue order; DEPTH must be a power of two.
module spi_tag_fifo
  import spi_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter from N_REQ requesters onto an SPI TX/RX FIFO pair with
// in-order read-response routing. Optional read timeout: SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_bridge_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TAG_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    SCLK,
  input  logic                    SRESET,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [FRAME_W-1:0]      Tx_FIFO_data_out,
  output logic                    Tx_FIFO_write_en,
  input  logic                    Tx_FIFO_full,
  input  logic [DATA_W-1:0]       Rx_FIFO_data_in,
  output logic                    Rx_FIFO_read_en,
  input  logic                    Rx_FIFO_empty,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err
);

  localparam int TAG_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_grant_oh;
  logic [N_REQ-1:0]   w_head_oh;
  logic [TAG_W-1:0]   w_grant_idx;
  logic [TAG_W-1:0]   w_idx;
  logic               w_hit;
  logic               w_found;
  logic               w_gate;
  logic               w_hs;
  logic [FRAME_W-1:0] w_sel_frame;
  logic               w_tag_push;
  logic               w_tag_pop;
  logic               w_tag_full;
  logic               w_tag_empty;
  logic [TAG_W-1:0]   w_tag_head;

  logic [TAG_W-1:0]   r_ptr;
  logic               r_tx_we;
  logic [FRAME_W-1:0] r_frame;

  rsp_state_e         r_state;
  rsp_state_e         w_state_nx;
  logic               r_rd_en;
  logic               w_rd_en_nx;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [N_REQ-1:0]   w_rsp_valid_nx;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [DATA_W-1:0]  w_rsp_data_nx;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]    r_to_cnt;
  logic [TO_W-1:0]    w_to_cnt_nx;
  logic               r_rsp_err;
  logic               w_rsp_err_nx;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  // A read may only be granted while there is room to remember its owner.
  assign w_elig     = req_valid & (req_write | {N_REQ{~w_tag_full}});
  assign w_gate     = ~SRESET & ~Tx_FIFO_full & ~r_tx_we;
  assign w_hs       = w_found & w_gate;
  assign w_tag_push = w_hs & ~req_write[w_grant_idx];

  // Search starts one past the last granted requester, wrapping at N_REQ.
  always_comb begin
    w_idx       = r_ptr;
    w_hit       = 1'b0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    w_sel_frame = '0;
    w_head_oh   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx       = (w_idx == TAG_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
      w_hit       = ~w_found & w_elig[w_idx];
      w_grant_idx = w_hit ? w_idx : w_grant_idx;
      w_found     = w_found | w_hit;
    end
    for (int i = 0; i < N_REQ; i++) begin
      w_grant_oh[i] = w_hs & (w_grant_idx == TAG_W'(i));
      w_head_oh[i]  = (w_tag_head == TAG_W'(i));
      w_sel_frame   = w_sel_frame |
                      ((w_grant_idx == TAG_W'(i)) ?
                       pack_frame(req_write[i], req_addr[ADDR_W*i +: ADDR_W],
                                  req_wdata[DATA_W*i +: DATA_W]) : '0);
    end
  end

  assign req_ready = w_grant_oh;

  // Frame register; the write-enable blocks the next grant, giving one frame per 2 cycles.
  always_ff @(posedge SCLK or posedge SRESET) begin
    if (SRESET) begin
      r_ptr   <= TAG_W'(N_REQ-1);
      r_tx_we <= 1'b0;
      r_frame <= '0;
    end else begin
      r_tx_we <= w_hs;
      if (w_hs) begin
        r_ptr   <= w_grant_idx;
        r_frame <= w_sel_frame;
      end
    end
  end

  assign Tx_FIFO_write_en = r_tx_we;
  assign Tx_FIFO_data_out = r_frame;

  spi_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (SCLK),
    .rst   (SRESET),
    .push  (w_tag_push),
    .pop   (w_tag_pop),
    .din   (w_grant_idx),
    .dout  (w_tag_head),
    .full  (w_tag_full),
    .empty (w_tag_empty)
  );

  // R_WAIT spans the pop cycle (r_rd_en high) and the data cycle that follows.
  always_comb begin
    w_state_nx     = r_state;
    w_rd_en_nx     = 1'b0;
    w_rsp_valid_nx = '0;
    w_rsp_data_nx  = r_rsp_data;
    w_tag_pop      = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    w_to_cnt_nx    = r_to_cnt;
    w_rsp_err_nx   = 1'b0;
`endif
    case (r_state)
      R_IDLE: begin
        if (!w_tag_empty && !Rx_FIFO_empty) begin
          w_state_nx = R_WAIT;
          w_rd_en_nx = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          w_to_cnt_nx = '0;
`endif
        end else begin
`ifdef SPI_ARB_TIMEOUT_EN
          if (!w_tag_empty) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYC-1)) begin
              w_state_nx     = R_DELIVER;
              w_rsp_valid_nx = w_head_oh;
              w_rsp_data_nx  = TIMEOUT_DATA;
              w_rsp_err_nx   = 1'b1;
              w_to_cnt_nx    = '0;
            end else begin
              w_to_cnt_nx = r_to_cnt + 1'b1;
            end
          end else begin
            w_to_cnt_nx = r_to_cnt;
          end
`else
          w_state_nx = R_IDLE;
`endif
        end
      end
      R_WAIT: begin
        if (r_rd_en) begin
          w_state_nx = R_WAIT;
        end else begin
          w_state_nx     = R_DELIVER;
          w_rsp_valid_nx = w_head_oh;
          w_rsp_data_nx  = Rx_FIFO_data_in;
        end
      end
      R_DELIVER: begin
        w_tag_pop  = 1'b1;
        w_state_nx = R_IDLE;
      end
      default: begin
        w_state_nx = R_IDLE;
      end
    endcase
  end

  // Response FSM state and registered response/pop outputs.
  always_ff @(posedge SCLK or posedge SRESET) begin
    if (SRESET) begin
      r_state     <= R_IDLE;
      r_rd_en     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_rd_en     <= w_rd_en_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_data  <= w_rsp_data_nx;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt    <= w_to_cnt_nx;
      r_rsp_err   <= w_rsp_err_nx;
`endif
    end
  end

  assign Rx_FIFO_read_en = r_rd_en;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed self-checking bench for spi_req_arbiter (default build, N_REQ=4).
module tb_spi_req_arbiter;

  logic         SCLK = 1'b0;
  logic         SRESET = 1'b1;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [40:0]  Tx_FIFO_data_out;
  logic         Tx_FIFO_write_en;
  logic         Tx_FIFO_full;
  logic [31:0]  Rx_FIFO_data_in;
  logic         Rx_FIFO_read_en;
  logic         Rx_FIFO_empty;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0]  ADDR  [4] = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};
  localparam logic [31:0] WDATA [4] = '{32'hA0A0_0000, 32'hB1B1_0001,
                                        32'hC2C2_0002, 32'hD3D3_0003};

  spi_req_arbiter #(.N_REQ(4), .TAG_DEPTH(4), .TIMEOUT_CYC(1024)) dut (
    .SCLK             (SCLK),
    .SRESET           (SRESET),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .Tx_FIFO_data_out (Tx_FIFO_data_out),
    .Tx_FIFO_write_en (Tx_FIFO_write_en),
    .Tx_FIFO_full     (Tx_FIFO_full),
    .Rx_FIFO_data_in  (Rx_FIFO_data_in),
    .Rx_FIFO_read_en  (Rx_FIFO_read_en),
    .Rx_FIFO_empty    (Rx_FIFO_empty),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err)
  );

  always #5 SCLK = ~SCLK;

  function automatic logic [40:0] exp_frame(input logic wr, input int i);
    return {wr, ADDR[i], (wr ? WDATA[i] : 32'h0000_0000)};
  endfunction

  task automatic step();
    @(posedge SCLK);
    @(negedge SCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int idx, input logic wr);
    logic [3:0] oh;
    oh        = 4'b0001 << idx;
    req_valid = oh;
    req_write = wr ? oh : 4'b0000;
    #1;
    chk("issue_ready", 64'(req_ready), 64'(oh));
    step();
    req_valid = 4'b0000;
    req_write = 4'b0000;
    #1;
    chk("issue_we", 64'(Tx_FIFO_write_en), 64'd1);
    chk("issue_frame", 64'(Tx_FIFO_data_out), 64'(exp_frame(wr, idx)));
    step();
    chk("issue_we_drop", 64'(Tx_FIFO_write_en), 64'd0);
  endtask

  task automatic rx_deliver(input logic [31:0] d, input logic [3:0] oh);
    logic seen;
    seen            = 1'b0;
    Rx_FIFO_data_in = d;
    Rx_FIFO_empty   = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = Rx_FIFO_read_en;
    end
    chk("rx_rd_en_seen", 64'(seen), 64'd1);
    Rx_FIFO_empty = 1'b1;
    step();
    chk("rx_rd_en_single", 64'(Rx_FIFO_read_en), 64'd0);
    chk("rsp_not_early", 64'(rsp_valid), 64'd0);
    step();
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_data", 64'(rsp_data), 64'(d));
    chk("rsp_err", 64'(rsp_err), 64'd0);
    step();
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [3:0] oh;
    logic       rd_seen;
    logic [3:0] rsp_seen;

    req_valid       = 4'b1111;
    req_write       = 4'b1111;
    req_addr        = {ADDR[3], ADDR[2], ADDR[1], ADDR[0]};
    req_wdata       = {WDATA[3], WDATA[2], WDATA[1], WDATA[0]};
    Tx_FIFO_full    = 1'b0;
    Rx_FIFO_data_in = 32'h0000_0000;
    Rx_FIFO_empty   = 1'b0;

    // Reset state with every request valid and RX data present
    step();
    step();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_tx_we", 64'(Tx_FIFO_write_en), 64'd0);
    chk("rst_tx_data", 64'(Tx_FIFO_data_out), 64'd0);
    chk("rst_rd_en", 64'(Rx_FIFO_read_en), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);

    // All writes: grants 0,1,2,3,0 on alternate cycles
    Rx_FIFO_empty = 1'b1;
    SRESET        = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      chk("rr_ready", 64'(req_ready), 64'(oh));
      step();
      chk("rr_we", 64'(Tx_FIFO_write_en), 64'd1);
      chk("rr_frame", 64'(Tx_FIFO_data_out), 64'(exp_frame(1'b1, g % 4)));
      chk("rr_ready_gap", 64'(req_ready), 64'd0);
      step();
      chk("rr_we_drop", 64'(Tx_FIFO_write_en), 64'd0);
    end
    req_valid = 4'b0000;
    req_write = 4'b0000;

    // Read from requester 2 at 8'h3C, response A5A5_0001
    issue(2, 1'b0);
    chk("rd2_frame_lit", 64'(Tx_FIFO_data_out), 64'h0_3C_0000_0000);
    rx_deliver(32'hA5A5_0001, 4'b0100);

    // Orphan RX data with no outstanding tag must not be popped
    Rx_FIFO_data_in = 32'h0BAD_0BAD;
    Rx_FIFO_empty   = 1'b0;
    rd_seen         = 1'b0;
    rsp_seen        = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      step();
      rd_seen  = rd_seen | Rx_FIFO_read_en;
      rsp_seen = rsp_seen | rsp_valid;
    end
    chk("orphan_no_pop", 64'(rd_seen), 64'd0);
    chk("orphan_no_rsp", 64'(rsp_seen), 64'd0);
    Rx_FIFO_empty = 1'b1;

    // In-order routing: reads from 1, 3, 0
    issue(1, 1'b0);
    issue(3, 1'b0);
    issue(0, 1'b0);
    rx_deliver(32'd11, 4'b0010);
    rx_deliver(32'd22, 4'b1000);
    rx_deliver(32'd33, 4'b0001);

    // Tag queue full: read from 0 blocked, write from 1 granted
    issue(0, 1'b0);
    issue(1, 1'b0);
    issue(2, 1'b0);
    issue(3, 1'b0);
    req_valid = 4'b0011;
    req_write = 4'b0010;
    #1;
    chk("full_write_only", 64'(req_ready), 64'b0010);
    step();
    req_valid = 4'b0000;
    req_write = 4'b0000;
    chk("full_write_we", 64'(Tx_FIFO_write_en), 64'd1);
    chk("full_write_frame", 64'(Tx_FIFO_data_out), 64'(exp_frame(1'b1, 1)));
    step();
    req_valid = 4'b0001;
    #1;
    chk("full_read_blocked", 64'(req_ready), 64'd0);
    req_valid = 4'b0000;
    rx_deliver(32'h0000_0100, 4'b0001);
    rx_deliver(32'h0000_0101, 4'b0010);
    rx_deliver(32'h0000_0102, 4'b0100);
    rx_deliver(32'h0000_0103, 4'b1000);

    // TX FIFO full for 10 cycles: no grants; release resumes after last grant (1)
    Tx_FIFO_full = 1'b1;
    req_valid    = 4'b1111;
    req_write    = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("txfull_ready", 64'(req_ready), 64'd0);
      step();
    end
    Tx_FIFO_full = 1'b0;
    #1;
    chk("txfull_release", 64'(req_ready), 64'b0100);
    req_valid = 4'b0000;

    // Reset with two reads outstanding discards them
    issue(2, 1'b0);
    issue(3, 1'b0);
    SRESET = 1'b1;
    #1;
    chk("midrst_tx_data", 64'(Tx_FIFO_data_out), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    SRESET          = 1'b0;
    Rx_FIFO_data_in = 32'h1234_5678;
    Rx_FIFO_empty   = 1'b0;
    rd_seen         = 1'b0;
    rsp_seen        = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step();
      rd_seen  = rd_seen | Rx_FIFO_read_en;
      rsp_seen = rsp_seen | rsp_valid;
    end
    chk("postrst_no_pop", 64'(rd_seen), 64'd0);
    chk("postrst_no_rsp", 64'(rsp_seen), 64'd0);
    req_valid = 4'b1111;
    req_write = 4'b1111;
    #1;
    chk("postrst_prio0", 64'(req_ready), 64'b0001);
    req_valid     = 4'b0000;
    req_write     = 4'b0000;
    Rx_FIFO_empty = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requester ports (2..8).
REQ-002 SHALL have parameter TAG_DEPTH, default 4, meaning the maximum number of outstanding reads (power of 2).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the read-response timeout in SCLK cycles (used only with SPI_ARB_TIMEOUT_EN).
REQ-004 SHALL have ports:
 SCLK  in  1  system clock; one clock only.
 SRESET  in  1  asynchronous, active-high reset.
 req_valid  in  N_REQ  per-requester transaction request.
 req_write  in  N_REQ  1=write, 0=read.
 req_addr  in  8*N_REQ  per-requester address, packed, requester i at [8i+7:8i].
 req_wdata  in  32*N_REQ  per-requester write data, packed.
 req_ready  out  N_REQ  grant; a handshake occurs when valid and ready are both high.
 Tx_FIFO_data_out  out  41  frame to TX FIFO.
 Tx_FIFO_write_en  out  1  TX FIFO push.
 Tx_FIFO_full  in  1  TX FIFO full flag.
 Rx_FIFO_data_in  in  32  RX FIFO read data, valid the cycle after the read enable.
 Rx_FIFO_read_en  out  1  RX FIFO pop.
 Rx_FIFO_empty  in  1  RX FIFO empty flag.
 rsp_valid  out  N_REQ  one-cycle read-response strobe to the owning requester.
 rsp_data  out  32  read-response data.
 rsp_err  out  1  response is a timeout error; driven 0 when SPI_ARB_TIMEOUT_EN is undefined.

Function
REQ-005 SHALL pack each frame as [40]=req_write, [39:32]=addr, [31:0]=wdata for writes or 32'd0 for reads.
REQ-006 SHALL treat requester i as eligible when req_valid[i]=1 and the request is a write, or the request is a read and the tag queue is not full.
REQ-007 SHALL assert req_ready (combinational) for exactly one eligible requester, only when Tx_FIFO_full=0 and Tx_FIFO_write_en=0; otherwise all req_ready bits SHALL be 0.
REQ-008 SHALL select round-robin, starting the search at the index after the last granted requester; the pointer SHALL update only on a handshake.
REQ-009 SHALL register the frame on a handshake, so that Tx_FIFO_write_en is high for exactly one cycle, the cycle after the handshake; issue rate SHALL be at most one frame per 2 cycles.
REQ-010 SHALL, on a read handshake, push the requester index into the tag queue in the handshake cycle.
REQ-011 SHALL implement the response FSM with states R_IDLE, R_WAIT and R_DELIVER:
 R_IDLE: go to R_WAIT when the tag queue is non-empty and Rx_FIFO_empty=0, with Rx_FIFO_read_en=1 for that single cycle (registered).
 R_WAIT: capture Rx_FIFO_data_in, then go to R_DELIVER.
 R_DELIVER: rsp_data=captured word, rsp_valid[head tag]=1 for one cycle, pop the tag, then return to R_IDLE.
REQ-012 SHALL never pop the RX FIFO while the tag queue is empty; orphan RX data SHALL stay in the FIFO.
REQ-013 SHALL support a tag push and pop in the same cycle, with the occupancy count unchanged.
REQ-014 SHALL have no response backpressure; requesters SHALL accept rsp_valid unconditionally.

Reset
REQ-015 SHALL, while SRESET=1, drive req_ready, Tx_FIFO_write_en, Rx_FIFO_read_en, rsp_valid, rsp_err to 0, Tx_FIFO_data_out to 41'd0 and rsp_data to 32'd0; set the RR pointer to N_REQ-1 so that requester 0 has first priority; empty the tag queue; and set the FSM to R_IDLE.
REQ-016 SHALL, on reset mid-transaction, discard outstanding tags; no rsp_valid SHALL be issued for pre-reset reads.

Configuration
REQ-017 SHALL, with SPI_ARB_TIMEOUT_EN defined, count cycles in R_IDLE while the tag queue is non-empty and Rx_FIFO_empty=1; on reaching TIMEOUT_CYC it SHALL deliver rsp_data=32'hDEAD_BEEF with rsp_err=1 to the head tag, pop the tag and clear the counter. The counter SHALL clear on every RX pop.
REQ-018 SHALL, without SPI_ARB_TIMEOUT_EN, have no counter, tie rsp_err to 0, and wait indefinitely.

Structure
REQ-019 SHALL place FRAME_W=41, ADDR_W=8, DATA_W=32, the frame bit positions, the response-FSM state typedef and TIMEOUT_DATA=32'hDEAD_BEEF in package spi_bridge_pkg.
REQ-020 SHALL implement the tag queue as sub-module spi_tag_fifo (parameters depth and width=$clog2(N_REQ); ports push, pop, din, dout, full, empty).

Verification
REQ-021 SHALL cover: req_valid=4'b1111, all writes, Tx_FIFO_full=0 -> grants 0,1,2,3,0 on alternate cycles; Tx_FIFO_write_en pulses 1 cycle after each handshake.
REQ-022 SHALL cover: req 2 reads addr 8'h3C -> frame 41'h0_3C_00000000 (bit40=0); RX FIFO returns 32'hA5A5_0001 -> rsp_valid=4'b0100 with that data 2 cycles after Rx_FIFO_read_en.
REQ-023 SHALL cover: reads from req 1, then 3, then 0; RX returns 11, 22, 33 -> responses delivered to 1, 3, 0 in that order.
REQ-024 SHALL cover: 4 outstanding reads (tag queue full) plus new read from req 0 and write from req 1 -> only req 1 is granted.
REQ-025 SHALL cover: Tx_FIFO_full=1 for 10 cycles with all valid -> req_ready=0 throughout; with SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16 and RX empty -> 32'hDEAD_BEEF with rsp_err=1 at cycle 16.
REQ-026 SHALL cover: SRESET pulse with 2 reads outstanding -> no rsp_valid afterwards and pending RX data not popped.
